// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative shift-add multiplier: one partial product per clock. This is the
// low-area member of the multiplier family. Operands arrive on a valid/ready
// handshake, and each transaction selects signed (two's-complement) or
// unsigned arithmetic. The 2*WIDTH-bit product leaves on a valid/ready
// handshake and is held for as long as the consumer stalls.
//
// Timing (k = accept edge):
//   non-zero operands : out_valid is set by edge k+WIDTH+1
//   a == 0 or b == 0  : out_valid is set by edge k+1
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand transaction valid
//   in_ready     block can accept operands (state == IDLE)
//   a            multiplicand, WIDTH bits
//   b            multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   out_valid    product valid
//   out_ready    consumer accepts product
//   p            product, 2*WIDTH bits
//   busy         high in CALC or DONE
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [PW-1:0]    r_mcand;     // multiplicand magnitude, shifted left each step
  logic [WIDTH:0]   r_mplier;    // multiplier magnitude, shifted right each step
  logic [PW-1:0]    r_acc;       // unsigned magnitude accumulator
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;       // result sign, latched at accept
  logic [PW-1:0]    r_p;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic             w_out_fire;

  // Magnitude of an operand, held in WIDTH+1 bits so that the negation of
  // -2^(WIDTH-1) (which does not fit in WIDTH signed bits) stays exact.
  function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x,
                                         input logic             sm);
    logic signed [WIDTH:0] sx;
    sx = signed'({x[WIDTH-1] & sm, x});
    if (sm && x[WIDTH-1]) begin
      return unsigned'(-sx);
    end
    return {1'b0, x};
  endfunction

  // Apply the latched sign to the accumulated magnitude, truncated to PW bits.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m,
                                               input logic          neg);
    logic signed [PW-1:0] sm;
    sm = signed'(m);
    return neg ? unsigned'(-sm) : m;
  endfunction

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_zero     = (a == '0) || (b == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH));
  assign w_out_fire = r_out_valid && out_ready;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign p         = r_p;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = CALC;
      CALC:    if (w_last)     w_state_nxt = DONE;
      DONE:    if (w_out_fire) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers.
  // A zero operand preloads the counter to its terminal value with an empty
  // multiplier, so the next edge finalises a zero accumulator. The product
  // appears one edge after accept and the finalise path is shared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= PW'(mag(a, signed_mode));
            r_mplier <= w_zero ? '0 : mag(b, signed_mode);
            r_acc    <= '0;
            r_cnt    <= w_zero ? CNT_W'(WIDTH) : '0;
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          if (w_last) begin
            r_p         <= apply_sign(r_acc, r_neg);
            r_out_valid <= 1'b1;
          end else begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;

  // WIDTH=8 instance
  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  // WIDTH=2 instance
  logic        iv2, ir2, sm2, ov2, or2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  int errors;
  int checks;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] p;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8),
    .out_ready(or8), .p(p8), .busy(busy8)
  );

  seq_shift_add_multiplier #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .signed_mode(sm2), .out_valid(ov2),
    .out_ready(or2), .p(p2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int sx, sy;
    sx = sm ? int'($signed(x)) : int'(x);
    sy = sm ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] x, input logic [1:0] y, input logic sm);
    int sx, sy;
    sx = sm ? int'($signed(x)) : int'(x);
    sy = sm ? int'($signed(y)) : int'(y);
    return 4'(sx * sy);
  endfunction

  // One full transaction on the WIDTH=8 instance with out_ready held high.
  // lat counts edges from the accept edge to the edge that raised out_valid.
  task automatic do_txn8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                         output logic [15:0] rp, output int lat);
    @(negedge clk);
    chk("in_ready_idle8", 64'(ir8), 64'd1);
    a8 = ta; b8 = tb; sm8 = tsm; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("in_ready_after_accept8", 64'(ir8), 64'd0);
    chk("busy_after_accept8", 64'(busy8), 64'd1);
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rp = p8;
    @(posedge clk); #1;
    chk("out_valid_cleared8", 64'(ov8), 64'd0);
    chk("back_to_idle8", 64'(ir8), 64'd1);
  endtask

  task automatic do_txn2(input logic [1:0] ta, input logic [1:0] tb, input logic tsm,
                         output logic [3:0] rp, output int lat);
    @(negedge clk);
    a2 = ta; b2 = tb; sm2 = tsm; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rp = p2;
    @(posedge clk); #1;
    chk("back_to_idle2", 64'(ir2), 64'd1);
  endtask

  initial begin
    logic [15:0] rp8;
    logic [3:0]  rp2;
    int          lat;
    logic [7:0]  ra, rb;
    logic        rsm;

    errors = 0;
    checks = 0;

    // a, b, signed_mode, expected p, expected latency
    vecs[0]  = '{8'd13,  8'd11,  1'b0, 16'd143,   9};
    vecs[1]  = '{8'd255, 8'd255, 1'b0, 16'hFE01,  9};
    vecs[2]  = '{8'h80,  8'h80,  1'b1, 16'h4000,  9};
    vecs[3]  = '{8'hFD,  8'd5,   1'b1, 16'hFFF1,  9};
    vecs[4]  = '{8'd0,   8'd200, 1'b0, 16'd0,     1};
    vecs[5]  = '{8'd7,   8'd0,   1'b1, 16'd0,     1};
    vecs[6]  = '{8'hFF,  8'hFF,  1'b1, 16'd1,     9};
    vecs[7]  = '{8'h80,  8'h7F,  1'b1, 16'hC080,  9};
    vecs[8]  = '{8'h80,  8'd1,   1'b0, 16'd128,   9};
    vecs[9]  = '{8'h7F,  8'h7F,  1'b1, 16'h3F01,  9};
    vecs[10] = '{8'hFF,  8'd2,   1'b0, 16'h01FE,  9};
    vecs[11] = '{8'hFF,  8'd2,   1'b1, 16'hFFFE,  9};

    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; or8 = 1'b1;
    iv2 = 1'b0; a2 = '0; b2 = '0; sm2 = 1'b0; or2 = 1'b1;

    #1;
    chk("reset_in_ready", 64'(ir8), 64'd1);
    chk("reset_out_valid", 64'(ov8), 64'd0);
    chk("reset_p", 64'(p8), 64'd0);
    chk("reset_busy", 64'(busy8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_txn8(vecs[i].a, vecs[i].b, vecs[i].sm, rp8, lat);
      chk($sformatf("vec%0d_p", i), 64'(rp8), 64'(vecs[i].p));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: 2*3 held for 20 stalled cycles while in_valid pulses are ignored
    or8 = 1'b0;
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("bp_first_valid", 64'(ov8), 64'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      iv8 = c[0]; a8 = 8'd50; b8 = 8'd50;
      @(posedge clk); #1;
      chk("bp_valid_held", 64'(ov8), 64'd1);
      chk("bp_p_held", 64'(p8), 64'd6);
      chk("bp_in_ready_low", 64'(ir8), 64'd0);
    end
    @(negedge clk);
    iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_ready", 64'(ir8), 64'd1);
    chk("bp_handshake_valid", 64'(ov8), 64'd0);
    chk("bp_p_kept", 64'(p8), 64'd6);
    @(negedge clk);
    iv8 = 1'b0;

    // Reset during CALC aborts immediately
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("midop_busy_before", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_out_valid", 64'(ov8), 64'd0);
    chk("midop_p", 64'(p8), 64'd0);
    chk("midop_in_ready", 64'(ir8), 64'd1);
    chk("midop_busy", 64'(busy8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_txn8(8'd9, 8'd9, 1'b0, rp8, lat);
    chk("post_reset_p", 64'(rp8), 64'd81);
    chk("post_reset_lat", 64'(lat), 64'd9);

    // WIDTH=2 exhaustive sweep, both modes
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          do_txn2(2'(x), 2'(y), m[0], rp2, lat);
          chk($sformatf("w2_p m%0d a%0d b%0d", m, x, y), 64'(rp2),
              64'(model2(2'(x), 2'(y), m[0])));
          chk($sformatf("w2_lat m%0d a%0d b%0d", m, x, y), 64'(lat),
              (x == 0 || y == 0) ? 64'd1 : 64'd3);
        end
      end
    end

    // WIDTH=8 random pairs in random modes
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rsm = 1'($urandom_range(0, 1));
      if (i % 50 == 0) ra = 8'd0;
      do_txn8(ra, rb, rsm, rp8, lat);
      chk($sformatf("rnd%0d_p a%0h b%0h s%0d", i, ra, rb, rsm), 64'(rp8),
          64'(model8(ra, rb, rsm)));
      chk($sformatf("rnd%0d_lat", i), 64'(lat),
          (ra == 8'd0 || rb == 8'd0) ? 64'd1 : 64'd9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised iterative shift-add multiplier. It is the sequential successor to the team's 2-bit/8-bit combinational multiplier blocks. The block takes WIDTH-bit operands through a valid/ready handshake and supports signed and unsigned modes per transaction. It returns a 2*WIDTH-bit product through a valid/ready handshake. It sits inside the RL design-space-exploration flow as the low-area point of the multiplier family, so it must be cycle-exact for the benches.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
p  output  2*WIDTH  product
busy  output  1  high in CALC or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - p = 0
  - busy = 0
  - internal accumulator, counter and sign flag = 0
- FSM states: IDLE, CALC, DONE.
- in_ready = (state == IDLE), decoded combinationally from registered state.
- busy = (state != IDLE).
- IDLE, accept when in_valid && in_ready at a rising edge:
  - Latch the operand magnitudes. In signed mode, a negative operand is replaced by its two's-complement negation, held zero-extended to WIDTH+1 bits so that -2^(WIDTH-1) is represented correctly.
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator and counter.
  - Go to CALC.
- Zero shortcut: if a == 0 or b == 0 at accept, go directly to DONE with p = 0 and out_valid = 1. Latency is 1 cycle.
- CALC, each cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplier right by 1 and the multiplicand left by 1.
  - Increment the counter.
- After WIDTH CALC cycles, load p = neg ? -acc : acc, truncated to 2*WIDTH bits. Set out_valid = 1 and go to DONE.
- Latency rule: for non-zero operands, out_valid is first high in the cycle after edge k+WIDTH+1, where k is the accept edge. That is WIDTH+1 edges after acceptance, fixed and data-independent.
- DONE:
  - p and out_valid hold stable while out_ready = 0 (backpressure is unlimited).
  - On out_valid && out_ready, clear out_valid and return to IDLE.
  - p keeps its last value after the handshake.
- No operand acceptance in the same cycle as the output handshake. The next accept can occur one edge later at the earliest.
- in_valid, a, b and signed_mode are ignored outside IDLE. Changing them mid-operation has no effect.
- Arithmetic rules:
  - Unsigned: p = a*b, exact in 2*WIDTH bits.
  - Signed: p = a*b as a 2*WIDTH-bit two's-complement value, exact for all inputs, including (-2^(WIDTH-1))^2.
- Reset asserted mid-operation aborts immediately:
  - All outputs return to their reset values asynchronously.
  - No partial product is ever presented.
- out_ready high while out_valid is low has no effect.

Test Plan:
- WIDTH=8, unsigned, a=13, b=11, out_ready=1 → in_ready drops after the accept edge; out_valid high exactly 9 edges after accept with p=143; state returns to IDLE on the next edge.
- Unsigned a=255, b=255 → p=65025 (0xFE01). Then signed a=0x80, b=0x80 → p=16384 (0x4000). Then signed a=0xFD (-3), b=5 → p=0xFFF1 (-15).
- Zero shortcut: a=0, b=200 → out_valid high 1 edge after accept, p=0. Repeat with a=7, b=0 and signed_mode=1 → same result.
- Backpressure: a=2, b=3 with out_ready=0 for 20 cycles → p=6 and out_valid held stable for the whole stall; in_ready=0 and in_valid pulses ignored; out_ready=1 completes the transaction and in_ready=1 on the next cycle.
- Reset mid-op: accept a=100, b=100, drop rst_n at CALC cycle 4 → out_valid=0, p=0 and in_ready=1 immediately. After release, a=9, b=9 → p=81 with full normal latency.
- Sweep: WIDTH=2 all 16 unsigned and 16 signed pairs, plus WIDTH=8 with 1000 random pairs in random modes, compared against a behavioural model → zero mismatches, constant latency, no out_valid glitches.
